// File: rtl/attempt_judge.sv
// Pin-guessing responder: judges stage-A then stage-B attempts against the armed pins,
// counts strikes and declares win or loss (strike-out or cronometer timeout).
module attempt_judge #(
   parameter int unsigned A_WIDTH     = 4,
   parameter int unsigned B_WIDTH     = 3,
   parameter int unsigned MAX_STRIKES = 3
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Done_Register,
   input  logic [A_WIDTH-1:0] A_Pin,
   input  logic [B_WIDTH-1:0] B_Pin,
   input  logic [A_WIDTH-1:0] Attempt_A,
   input  logic               Attempt_A_Valid,
   input  logic [B_WIDTH-1:0] Attempt_B,
   input  logic               Attempt_B_Valid,
   input  logic               Time_Over,
   output logic               Start_B,
   output logic [1:0]         Attempt_State,
   output logic               Result_Valid,
   output logic               Penalty,
   output logic [2:0]         Strikes,
   output logic               Game_Won,
   output logic               Game_Lost
);

   localparam logic [1:0] VerdictNone = 2'b00;
   localparam logic [1:0] VerdictLow  = 2'b01;
   localparam logic [1:0] VerdictHigh = 2'b10;
   localparam logic [1:0] VerdictHit  = 2'b11;
   localparam logic [2:0] StrikeLimit = 3'(MAX_STRIKES);

   typedef enum logic [2:0] {
      StIdle,
      StStageA,
      StStageB,
      StWon,
      StLost
   } state_e;

   state_e     state;
   logic       in_stage_b;
   logic       stage_valid;
   logic [1:0] verdict_a;
   logic [1:0] verdict_b;
   logic [1:0] verdict;
   logic [2:0] strikes_inc;
   logic       strike_out;

   always_comb begin
      verdict_a = VerdictHit;
      if (Attempt_A < A_Pin) begin
         verdict_a = VerdictLow;
      end else if (Attempt_A > A_Pin) begin
         verdict_a = VerdictHigh;
      end

      verdict_b = VerdictHit;
      if (Attempt_B < B_Pin) begin
         verdict_b = VerdictLow;
      end else if (Attempt_B > B_Pin) begin
         verdict_b = VerdictHigh;
      end

      // Only the strobe belonging to the current stage is ever honoured.
      in_stage_b  = (state == StStageB);
      stage_valid = in_stage_b ? Attempt_B_Valid : Attempt_A_Valid;
      verdict     = in_stage_b ? verdict_b : verdict_a;

      strikes_inc = (Strikes >= StrikeLimit) ? StrikeLimit : Strikes + 3'd1;
      strike_out  = (strikes_inc >= StrikeLimit);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= StIdle;
         Start_B       <= 1'b0;
         Attempt_State <= VerdictNone;
         Result_Valid  <= 1'b0;
         Penalty       <= 1'b0;
         Strikes       <= 3'd0;
         Game_Won      <= 1'b0;
         Game_Lost     <= 1'b0;
      end else begin
         Result_Valid <= 1'b0;
         Penalty      <= 1'b0;

         case (state)
            StIdle: begin
               if (Done_Register) begin
                  state         <= StStageA;
                  Strikes       <= 3'd0;
                  Attempt_State <= VerdictNone;
               end
            end

            StStageA, StStageB: begin
               if (!Done_Register) begin
                  // Silent abort: configuration withdrawn mid-game.
                  state         <= StIdle;
                  Start_B       <= 1'b0;
                  Attempt_State <= VerdictNone;
                  Strikes       <= 3'd0;
               end else if (Time_Over) begin
                  // Timeout beats any attempt arriving in the same cycle.
                  state     <= StLost;
                  Start_B   <= 1'b0;
                  Game_Lost <= 1'b1;
               end else if (stage_valid) begin
                  Attempt_State <= verdict;
                  Result_Valid  <= 1'b1;
                  if (verdict == VerdictHit) begin
                     if (in_stage_b) begin
                        state    <= StWon;
                        Start_B  <= 1'b0;
                        Game_Won <= 1'b1;
                     end else begin
                        state   <= StStageB;
                        Start_B <= 1'b1;
                     end
                  end else begin
                     Penalty <= 1'b1;
                     Strikes <= strikes_inc;
                     if (strike_out) begin
                        state     <= StLost;
                        Start_B   <= 1'b0;
                        Game_Lost <= 1'b1;
                     end
                  end
               end
            end

            StWon, StLost: begin
               if (!Done_Register) begin
                  state         <= StIdle;
                  Start_B       <= 1'b0;
                  Attempt_State <= VerdictNone;
                  Strikes       <= 3'd0;
                  Game_Won      <= 1'b0;
                  Game_Lost     <= 1'b0;
               end
            end

            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_attempt_judge.sv
// Table-driven bench for attempt_judge: one row per clock, expected outputs hand-computed,
// plus hand-written reset sequences.
module tb_attempt_judge;

   logic       Clk;
   logic       Reset;
   logic       Done_Register;
   logic [3:0] A_Pin;
   logic [2:0] B_Pin;
   logic [3:0] Attempt_A;
   logic       Attempt_A_Valid;
   logic [2:0] Attempt_B;
   logic       Attempt_B_Valid;
   logic       Time_Over;
   logic       Start_B;
   logic [1:0] Attempt_State;
   logic       Result_Valid;
   logic       Penalty;
   logic [2:0] Strikes;
   logic       Game_Won;
   logic       Game_Lost;

   attempt_judge #(
      .A_WIDTH     (4),
      .B_WIDTH     (3),
      .MAX_STRIKES (3)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Done_Register   (Done_Register),
      .A_Pin           (A_Pin),
      .B_Pin           (B_Pin),
      .Attempt_A       (Attempt_A),
      .Attempt_A_Valid (Attempt_A_Valid),
      .Attempt_B       (Attempt_B),
      .Attempt_B_Valid (Attempt_B_Valid),
      .Time_Over       (Time_Over),
      .Start_B         (Start_B),
      .Attempt_State   (Attempt_State),
      .Result_Valid    (Result_Valid),
      .Penalty         (Penalty),
      .Strikes         (Strikes),
      .Game_Won        (Game_Won),
      .Game_Lost       (Game_Lost)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Outputs packed as {Start_B, Attempt_State, Result_Valid, Penalty, Strikes, Game_Won, Game_Lost}
   typedef struct {
      logic       dn;
      logic [3:0] ap;
      logic [2:0] bp;
      logic [3:0] aa;
      logic       av;
      logic [2:0] ab;
      logic       bv;
      logic       to;
      logic [9:0] exp;
   } vec_t;

   vec_t       vecs[$];
   int         total = 0;
   int         bad = 0;
   logic [9:0] act;

   assign act = {Start_B, Attempt_State, Result_Valid, Penalty, Strikes, Game_Won, Game_Lost};

   function automatic vec_t v(input int dn, input int ap, input int bp, input int aa,
                              input int av, input int ab, input int bv, input int to,
                              input int sb, input int as, input int rv, input int pn,
                              input int st, input int w, input int l);
      vec_t r;
      r.dn  = 1'(dn);
      r.ap  = 4'(ap);
      r.bp  = 3'(bp);
      r.aa  = 4'(aa);
      r.av  = 1'(av);
      r.ab  = 3'(ab);
      r.bv  = 1'(bv);
      r.to  = 1'(to);
      r.exp = {1'(sb), 2'(as), 1'(rv), 1'(pn), 3'(st), 1'(w), 1'(l)};
      return r;
   endfunction

   task automatic check(input string name, input logic [9:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got {sb,as,rv,pn,st,w,l}=%b want=%b", name, act, want);
      end
   endtask

   task automatic drive(input vec_t r);
      Done_Register   = r.dn;
      A_Pin           = r.ap;
      B_Pin           = r.bp;
      Attempt_A       = r.aa;
      Attempt_A_Valid = r.av;
      Attempt_B       = r.ab;
      Attempt_B_Valid = r.bv;
      Time_Over       = r.to;
   endtask

   initial begin
      //                dn ap bp aa av ab bv to   sb as rv pn st w  l
      vecs.push_back(v(0, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 9, 1, 0, 0, 0,   1, 3, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 0, 0, 5, 1, 0,   0, 3, 1, 0, 0, 1, 0));
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 1,   0, 3, 0, 0, 0, 1, 0));
      vecs.push_back(v(0, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // direction hints, then strike-out in stage B with carried strikes
      vecs.push_back(v(1, 6, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 6, 5, 3, 1, 0, 0, 0,   0, 1, 1, 1, 1, 0, 0));
      vecs.push_back(v(1, 6, 5, 12, 1, 0, 0, 0,  0, 2, 1, 1, 2, 0, 0));
      vecs.push_back(v(1, 6, 5, 6, 1, 0, 0, 0,   1, 3, 1, 0, 2, 0, 0));
      vecs.push_back(v(1, 6, 5, 6, 1, 0, 0, 0,   1, 3, 0, 0, 2, 0, 0));
      vecs.push_back(v(1, 6, 5, 0, 0, 7, 1, 0,   0, 2, 1, 1, 3, 0, 1));
      vecs.push_back(v(1, 6, 5, 0, 0, 5, 1, 0,   0, 2, 0, 0, 3, 0, 1));
      vecs.push_back(v(0, 6, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // wrong-stage strobe, then three wrong B attempts
      vecs.push_back(v(1, 2, 4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 2, 4, 0, 0, 4, 1, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 2, 4, 2, 1, 0, 0, 0,   1, 3, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 2, 4, 0, 0, 0, 1, 0,   1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(v(1, 2, 4, 0, 0, 7, 1, 0,   1, 2, 1, 1, 2, 0, 0));
      vecs.push_back(v(1, 2, 4, 0, 0, 1, 1, 0,   0, 1, 1, 1, 3, 0, 1));
      vecs.push_back(v(1, 2, 4, 0, 0, 4, 1, 0,   0, 1, 0, 0, 3, 0, 1));
      vecs.push_back(v(0, 2, 4, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // timeout beats a correct attempt
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 9, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // abort from stage B with one strike
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 9, 1, 0, 0, 0,   1, 3, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 0, 0, 6, 1, 0,   1, 2, 1, 1, 1, 0, 0));
      vecs.push_back(v(0, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // timeout in stage B
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 9, 1, 0, 0, 0,   1, 3, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 5, 0, 0, 0, 0, 1,   0, 3, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 9, 5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0));
      // full-width extremes; both strobes together in stage A
      vecs.push_back(v(1, 15, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 15, 5, 0, 1, 0, 0, 0,  0, 1, 1, 1, 1, 0, 0));
      vecs.push_back(v(1, 15, 5, 15, 1, 3, 1, 0, 1, 3, 1, 0, 1, 0, 0));
      vecs.push_back(v(0, 15, 5, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

      Reset = 1'b1;
      drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      @(posedge Clk);
      #1;
      check("reset", 10'b0);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(posedge Clk);
         #1;
         check($sformatf("row%0d", i), vecs[i].exp);
         total++;
         if (Game_Won && Game_Lost) begin
            bad++;
            $display("FAIL row%0d_exclusive got won=%b lost=%b want not both", i, Game_Won,
                     Game_Lost);
         end
      end

      // Asynchronous reset mid stage B must clear outputs before the next edge.
      drive(v(1, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      #1;
      drive(v(1, 9, 5, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      #1;
      check("pre_reset_stage_b", 10'b1_11_1_0_000_0_0);
      drive(v(1, 9, 5, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      #1;
      check("pre_reset_strike", 10'b1_01_1_1_001_0_0);
      drive(v(1, 9, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      Reset = 1'b1;
      #1;
      check("async_reset", 10'b0);
      @(posedge Clk);
      #1;
      check("reset_held", 10'b0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      check("rearm_after_reset", 10'b0);
      drive(v(1, 9, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge Clk);
      #1;
      check("after_reset_low", 10'b0_01_1_1_001_0_0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/attempt_judge.md
Name: attempt_judge

Overview:
- Responder side of the pin-guessing interface: compares player attempts against the armed A and B pins and returns per-attempt verdicts.
- Sequences the game: stage A first; stage B is enabled only after A is solved. Issues Start_B and Attempt_State to the stage-B attempt block.
- Declares win or loss from a strike limit and the cronometer timeout.
- Sits between pin configuration, the attempt entry blocks and the cronometer.

Parameters:
A_WIDTH, 4, width of A pin and stage-A attempt
B_WIDTH, 3, width of B pin and stage-B attempt
MAX_STRIKES, 3, wrong attempts allowed before loss (range 1..7)

Ports:
Clk  input  1  system clock (CLOCK_50 domain)
Reset  input  1  asynchronous, active-high; clears all state
Done_Register  input  1  level; high while A_Pin/B_Pin are armed and valid
A_Pin  input  A_WIDTH  secret A value
B_Pin  input  B_WIDTH  secret B value
Attempt_A  input  A_WIDTH  stage-A guess
Attempt_A_Valid  input  1  one-cycle strobe; Attempt_A is sampled this cycle
Attempt_B  input  B_WIDTH  stage-B guess
Attempt_B_Valid  input  1  one-cycle strobe; Attempt_B is sampled this cycle
Time_Over  input  1  level from cronometer
Start_B  output  1  level; high while in STAGE_B
Attempt_State  output  2  last verdict: 00 none, 01 too low, 10 too high, 11 correct
Result_Valid  output  1  one-cycle pulse when Attempt_State updates
Penalty  output  1  one-cycle pulse on each wrong attempt
Strikes  output  3  wrong attempts in the current game
Game_Won  output  1  level; high in WON
Game_Lost  output  1  level; high in LOST

Behaviour:
- Reset value of all outputs: 0. State resets to IDLE.
- States are IDLE, STAGE_A, STAGE_B, WON and LOST. All outputs are registered.
- Transitions out of each state:
  - IDLE -> STAGE_A when Done_Register=1. Strikes and Attempt_State clear on entry.
  - STAGE_A on Attempt_A_Valid:
    - Attempt_A==A_Pin: Attempt_State=11, go to STAGE_B.
    - Attempt_A<A_Pin: Attempt_State=01.
    - Attempt_A>A_Pin: Attempt_State=10.
    - Any wrong attempt: Strikes+1 and Penalty pulses.
  - STAGE_B: same rules using Attempt_B and B_Pin. A correct attempt goes to WON.
  - Reaching Strikes==MAX_STRIKES after a wrong attempt goes to LOST in the same update.
  - WON and LOST are terminal. They leave only on Reset, or on Done_Register falling, which goes to IDLE.
- Latency: a verdict is visible on Attempt_State, Result_Valid and Penalty 1 cycle after the valid strobe. State changes in that same cycle, so Start_B rises 1 cycle after a correct A.
- Comparisons are unsigned at full width.
- Strikes saturates at MAX_STRIKES and never wraps.
- Attempt strobes are ignored in every state other than the matching stage:
  - Attempt_B_Valid in STAGE_A is ignored.
  - Attempt_A_Valid in STAGE_B is ignored.
  - Both strobes in the same cycle: only the strobe for the current stage is honoured.
- Time_Over=1 in STAGE_A or STAGE_B goes to LOST on the next edge.
  - Time_Over takes priority over a correct attempt in the same cycle: result is LOST, no Result_Valid.
  - Time_Over in WON has no effect.
- Done_Register falling in STAGE_A or STAGE_B aborts to IDLE. Strikes, Attempt_State and Start_B clear, and no pulse is emitted.
- Reset mid-game: immediate asynchronous return to IDLE with all outputs 0.
- Game_Won and Game_Lost are never both 1.

Test Plan:
- Happy path: A_Pin=9, B_Pin=5, Done_Register=1; Attempt_A=9 strobe, then Attempt_B=5 strobe -> Attempt_State=11 with Result_Valid each time; Start_B=1 one cycle after A; Game_Won=1; Strikes=0.
- Direction hints: A_Pin=6; attempts 3, then 12, then 6 -> Attempt_State 01, 10, 11; Penalty pulses twice; Strikes=2; Start_B=1.
- Strike-out: MAX_STRIKES=3, B_Pin=4 in STAGE_B; Attempt_B=0, 7, 1 -> third verdict sets Game_Lost=1; Strikes=3; further strobes produce no Result_Valid.
- Priority: in STAGE_A, correct Attempt_A_Valid and Time_Over=1 in the same cycle -> LOST, Game_Won=0, no Result_Valid.
- Wrong-stage strobe: in STAGE_A pulse Attempt_B_Valid with Attempt_B=B_Pin -> no response, state unchanged.
- Abort and reset: in STAGE_B with Strikes=1, drop Done_Register -> IDLE, all outputs 0. Re-arm and assert Reset asynchronously mid-stage -> outputs 0 before the next Clk edge.
